// File: rtl/alu_pkg.sv
// Shared constants for the round-robin shared ALU: widths, opcode map and
// the three-state controller encoding.
package alu_pkg;

  localparam int WIDTH  = 8;
  localparam int OP_W   = 5;
  localparam int MAX_OP = 18;

  // Opcode map of the shared ALU (ALU_Sel values)
  localparam logic [4:0] ALU_OP_ADD  = 5'd0;
  localparam logic [4:0] ALU_OP_SUB  = 5'd1;
  localparam logic [4:0] ALU_OP_MUL  = 5'd2;
  localparam logic [4:0] ALU_OP_DIV  = 5'd3;
  localparam logic [4:0] ALU_OP_SHL  = 5'd4;
  localparam logic [4:0] ALU_OP_SHR  = 5'd5;
  localparam logic [4:0] ALU_OP_ROL  = 5'd6;
  localparam logic [4:0] ALU_OP_ROR  = 5'd7;
  localparam logic [4:0] ALU_OP_AND  = 5'd8;
  localparam logic [4:0] ALU_OP_OR   = 5'd9;
  localparam logic [4:0] ALU_OP_XOR  = 5'd10;
  localparam logic [4:0] ALU_OP_NOR  = 5'd11;
  localparam logic [4:0] ALU_OP_NAND = 5'd12;
  localparam logic [4:0] ALU_OP_XNOR = 5'd13;
  localparam logic [4:0] ALU_OP_GT   = 5'd14;
  localparam logic [4:0] ALU_OP_EQ   = 5'd15;
  localparam logic [4:0] ALU_OP_INC  = 5'd16;
  localparam logic [4:0] ALU_OP_DEC  = 5'd17;
  localparam logic [4:0] ALU_OP_NOT  = 5'd18;

  // Controller states
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

endpackage

// File: rtl/alu.sv
// Combinational ALU shared by both requesters. Carry is the ADD carry-out,
// the SUB borrow, the bit shifted out by SHL/SHR, and the wrap flag of INC/DEC;
// every other operation reports carry 0. Division by zero returns all ones.
module alu
#(
  parameter int DW = alu_pkg::WIDTH,
  parameter int SW = alu_pkg::OP_W
)
(
  input  logic [DW-1:0] A,
  input  logic [DW-1:0] B,
  input  logic [SW-1:0] ALU_Sel,
  output logic [DW-1:0] ALU_Out,
  output logic          ALU_Carry
);
  import alu_pkg::*;

  logic [DW:0] sum_s;

  // Result and carry selection for every opcode
  always_comb begin
    sum_s     = {1'b0, A} + {1'b0, B};
    ALU_Out   = {DW{1'b0}};
    ALU_Carry = 1'b0;
    case (ALU_Sel)
      ALU_OP_ADD: begin ALU_Out = sum_s[DW-1:0]; ALU_Carry = sum_s[DW]; end
      ALU_OP_SUB: begin ALU_Out = A - B; ALU_Carry = (A < B); end
      ALU_OP_MUL: ALU_Out = A * B;
      ALU_OP_DIV: begin
        if (B == {DW{1'b0}}) begin
          ALU_Out = {DW{1'b1}};
        end else begin
          ALU_Out = A / B;
        end
      end
      ALU_OP_SHL: begin ALU_Out = {A[DW-2:0], 1'b0}; ALU_Carry = A[DW-1]; end
      ALU_OP_SHR: begin ALU_Out = {1'b0, A[DW-1:1]}; ALU_Carry = A[0]; end
      ALU_OP_ROL:  ALU_Out = {A[DW-2:0], A[DW-1]};
      ALU_OP_ROR:  ALU_Out = {A[0], A[DW-1:1]};
      ALU_OP_AND:  ALU_Out = A & B;
      ALU_OP_OR:   ALU_Out = A | B;
      ALU_OP_XOR:  ALU_Out = A ^ B;
      ALU_OP_NOR:  ALU_Out = ~(A | B);
      ALU_OP_NAND: ALU_Out = ~(A & B);
      ALU_OP_XNOR: ALU_Out = ~(A ^ B);
      ALU_OP_GT:   ALU_Out = {{(DW-1){1'b0}}, (A > B)};
      ALU_OP_EQ:   ALU_Out = {{(DW-1){1'b0}}, (A == B)};
      ALU_OP_INC: begin ALU_Out = A + {{(DW-1){1'b0}}, 1'b1}; ALU_Carry = &A; end
      ALU_OP_DEC: begin ALU_Out = A - {{(DW-1){1'b0}}, 1'b1}; ALU_Carry = ~|A; end
      ALU_OP_NOT:  ALU_Out = ~A;
      default: begin ALU_Out = {DW{1'b0}}; ALU_Carry = 1'b0; end
    endcase
  end

endmodule

// File: rtl/alu_rr_arb2.sv
// Two-way round-robin grant: ptr selects which requester wins a tie,
// and a lone requester always wins.
module alu_rr_arb2 (
  input  logic valid0,
  input  logic valid1,
  input  logic ptr,
  output logic grant0,
  output logic grant1
);

  // Grant decode; grants are mutually exclusive by construction
  always_comb begin
    grant0 = valid0 & (~ptr | ~valid1);
    grant1 = valid1 & ~grant0;
  end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Shares one ALU between two valid/ready requesters. One operation is in
// flight at a time: IDLE grants and latches operands, EXEC registers the ALU
// result, RESP holds the tagged response until the consumer takes it.
module alu_rr_arbiter
#(
  parameter int WIDTH  = alu_pkg::WIDTH,
  parameter int OP_W   = alu_pkg::OP_W,
  parameter int MAX_OP = alu_pkg::MAX_OP
)
(
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OP_W-1:0]  req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OP_W-1:0]  req1_op,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_out,
  output logic             rsp_carry,
  output logic             rsp_err,
  output logic             busy
);
  import alu_pkg::*;

  localparam logic [OP_W-1:0] MAX_OP_L = OP_W'(MAX_OP);

  logic [1:0]       state_r;
  logic             ptr_r;
  logic [WIDTH-1:0] opa_r;
  logic [WIDTH-1:0] opb_r;
  logic [OP_W-1:0]  opc_r;
  logic             id_r;
  logic             grant0_s;
  logic             grant1_s;
  logic             accept_s;
  logic [WIDTH-1:0] alu_out_s;
  logic             alu_carry_s;
  logic             op_legal_s;

  alu_rr_arb2 u_arb (
    .valid0 (req0_valid),
    .valid1 (req1_valid),
    .ptr    (ptr_r),
    .grant0 (grant0_s),
    .grant1 (grant1_s)
  );

  alu #(.DW(WIDTH), .SW(OP_W)) u_alu (
    .A         (opa_r),
    .B         (opb_r),
    .ALU_Sel   (opc_r),
    .ALU_Out   (alu_out_s),
    .ALU_Carry (alu_carry_s)
  );

  // Ready only in IDLE; forced low while reset is asserted
  assign req0_ready = grant0_s & (state_r == S_IDLE) & ~rst;
  assign req1_ready = grant1_s & (state_r == S_IDLE) & ~rst;
  assign accept_s   = (grant0_s | grant1_s) & (state_r == S_IDLE);
  assign busy       = (state_r != S_IDLE);
  assign op_legal_s = (opc_r <= MAX_OP_L);

  // Controller state and round-robin pointer (winner hands priority to the other side)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_IDLE;
      ptr_r   <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (accept_s) begin
            ptr_r   <= ~grant1_s;
            state_r <= S_EXEC;
          end
        end
        S_EXEC: state_r <= S_RESP;
        S_RESP: begin
          if (rsp_ready) begin
            state_r <= S_IDLE;
          end
        end
        default: state_r <= S_IDLE;
      endcase
    end
  end

  // Operand registers: the ALU only ever sees these, never the live request inputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opa_r <= {WIDTH{1'b0}};
      opb_r <= {WIDTH{1'b0}};
      opc_r <= {OP_W{1'b0}};
      id_r  <= 1'b0;
    end else if (accept_s) begin
      opa_r <= grant1_s ? req1_a  : req0_a;
      opb_r <= grant1_s ? req1_b  : req0_b;
      opc_r <= grant1_s ? req1_op : req0_op;
      id_r  <= grant1_s;
    end
  end

  // Response registers: capture at the end of EXEC, hold until the handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_out   <= {WIDTH{1'b0}};
      rsp_carry <= 1'b0;
      rsp_err   <= 1'b0;
    end else if (state_r == S_EXEC) begin
      rsp_valid <= 1'b1;
      rsp_id    <= id_r;
      rsp_out   <= op_legal_s ? alu_out_s : {WIDTH{1'b0}};
      rsp_carry <= op_legal_s & alu_carry_s;
      rsp_err   <= ~op_legal_s;
    end else if ((state_r == S_RESP) && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed bench for alu_rr_arbiter. The stimulus pushes hand-computed
// responses into a queue at grant time; an independent monitor pops and
// compares on every response handshake.
module tb_alu_rr_arbiter;

  logic       clk;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic       req0_ready, req1_ready;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic [4:0] req0_op, req1_op;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_carry, rsp_err, busy;
  logic [7:0] rsp_out;

  typedef struct {
    logic       id;
    logic [7:0] out;
    logic       carry;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  alu_rr_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_out    (rsp_out),
    .rsp_carry  (rsp_carry),
    .rsp_err    (rsp_err),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return {17'd0, req0_ready, req1_ready, rsp_valid, rsp_id, rsp_carry, rsp_err, busy, rsp_out};
  endfunction

  // Monitor: every response handshake must match the oldest expectation
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        chk("rsp_unexpected", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_fields", {21'd0, rsp_id, rsp_out, rsp_carry, rsp_err},
            {21'd0, e.id, e.out, e.carry, e.err});
      end
    end
  end

  task automatic idle_inputs();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  // Called at posedge+1; returns at posedge+1 just after the accepting edge
  task automatic run_op(input logic v0, input logic [7:0] a0, input logic [7:0] b0, input logic [4:0] op0,
                        input logic v1, input logic [7:0] a1, input logic [7:0] b1, input logic [4:0] op1,
                        input logic exp_id, input logic [7:0] e_out, input logic e_c, input logic e_err,
                        input bit push);
    bit seen;
    exp_t e;
    req0_valid = v0; req0_a = a0; req0_b = b0; req0_op = op0;
    req1_valid = v1; req1_a = a1; req1_b = b1; req1_op = op1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) begin
      chk("grant_timeout", 32'd0, 32'd1);
    end else begin
      chk("grant_id", {30'd0, req1_ready, req0_ready}, exp_id ? 32'd2 : 32'd1);
      if (push) begin
        e.id = exp_id; e.out = e_out; e.carry = e_c; e.err = e_err;
        exp_q.push_back(e);
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    chk("drain", {31'd0, done}, 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("reset_outputs", all_outs(), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    rsp_ready = 1'b1;
    idle_inputs();
    req0_a = 8'h00; req0_b = 8'h00; req0_op = 5'd0;
    req1_a = 8'h00; req1_b = 8'h00; req1_op = 5'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", all_outs(), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: single ADD with cycle-level latency checks
    req0_valid = 1'b1; req0_a = 8'hC9; req0_b = 8'hEC; req0_op = 5'd0;
    @(negedge clk);
    chk("t1_ready", {29'd0, req0_ready, busy, rsp_valid}, 32'b100);
    exp_q.push_back('{id: 1'b0, out: 8'hB5, carry: 1'b1, err: 1'b0});
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    chk("t1_exec", {29'd0, req0_ready, busy, rsp_valid}, 32'b010);
    @(negedge clk);
    chk("t1_resp", {29'd0, req0_ready, busy, rsp_valid}, 32'b011);
    @(negedge clk);
    chk("t1_back_idle", {29'd0, req0_ready, busy, rsp_valid}, 32'b000);
    @(posedge clk); #1;

    // 2: both requesters held valid, grants alternate starting from req0
    do_reset();
    run_op(1'b1, 8'h10, 8'h20, 5'd0,  1'b1, 8'h50, 8'h60, 5'd1, 1'b0, 8'h30, 1'b0, 1'b0, 1'b1);
    run_op(1'b1, 8'hF0, 8'h0F, 5'd8,  1'b1, 8'h50, 8'h60, 5'd1, 1'b1, 8'hF0, 1'b1, 1'b0, 1'b1);
    run_op(1'b1, 8'hF0, 8'h0F, 5'd8,  1'b1, 8'h81, 8'h00, 5'd4, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    run_op(1'b1, 8'h33, 8'h0F, 5'd10, 1'b1, 8'h81, 8'h00, 5'd4, 1'b1, 8'h02, 1'b1, 1'b0, 1'b1);
    run_op(1'b1, 8'h33, 8'h0F, 5'd10, 1'b0, 8'h00, 8'h00, 5'd0, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
    idle_inputs();
    wait_idle();

    // 3: backpressure holds the response and blocks new grants
    rsp_ready = 1'b0;
    run_op(1'b1, 8'h7F, 8'h01, 5'd0, 1'b0, 8'h00, 8'h00, 5'd0, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1);
    req0_valid = 1'b0;
    req1_valid = 1'b1; req1_a = 8'h0A; req1_b = 8'h03; req1_op = 5'd2;
    begin
      bit got_rsp;
      got_rsp = 1'b0;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        if (rsp_valid) begin got_rsp = 1'b1; break; end
      end
      chk("t3_rsp_seen", {31'd0, got_rsp}, 32'd1);
      for (int k = 0; k < 5; k++) begin
        if (k != 0) @(negedge clk);
        chk("t3_hold", {19'd0, rsp_valid, rsp_id, rsp_out, rsp_carry, rsp_err, req0_ready, req1_ready},
            {19'd0, 1'b1, 1'b0, 8'h80, 1'b0, 1'b0, 1'b0, 1'b0});
      end
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("t3_idle_after", {30'd0, busy, req1_ready}, 32'b01);
    exp_q.push_back('{id: 1'b1, out: 8'h1E, carry: 1'b0, err: 1'b0});
    @(posedge clk); #1;
    idle_inputs();
    wait_idle();

    // 4: illegal opcodes and the highest legal one
    run_op(1'b1, 8'h12, 8'h34, 5'd19, 1'b0, 8'h00, 8'h00, 5'd0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    idle_inputs();
    wait_idle();
    run_op(1'b1, 8'hFF, 8'hFF, 5'd31, 1'b0, 8'h00, 8'h00, 5'd0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    idle_inputs();
    wait_idle();
    run_op(1'b1, 8'h5A, 8'h00, 5'd18, 1'b0, 8'h00, 8'h00, 5'd0, 1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
    idle_inputs();
    wait_idle();

    // 5: reset during EXEC drops the transaction and returns priority to req0
    run_op(1'b1, 8'h01, 8'h01, 5'd0, 1'b0, 8'h00, 8'h00, 5'd0, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0);
    #1;
    rst = 1'b1;
    #1;
    chk("t5_rst_outputs", all_outs(), 32'd0);
    idle_inputs();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t5_no_rsp", {30'd0, rsp_valid, busy}, 32'd0);
    end
    @(posedge clk); #1;
    run_op(1'b1, 8'h04, 8'h05, 5'd9, 1'b1, 8'h06, 8'h07, 5'd8, 1'b0, 8'h05, 1'b0, 1'b0, 1'b1);
    idle_inputs();
    wait_idle();

    // 6: lone req1 with ptr at req0, then a tie goes to req0
    do_reset();
    run_op(1'b0, 8'h00, 8'h00, 5'd0, 1'b1, 8'h80, 8'h80, 5'd0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b1);
    idle_inputs();
    wait_idle();
    run_op(1'b1, 8'h02, 8'h03, 5'd1, 1'b1, 8'h11, 8'h22, 5'd9, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b1);
    idle_inputs();
    wait_idle();

    chk("queue_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
